// File: rtl/xilinx_fifo_rd_stream_adapter.sv
// Read-side consumer for the async FIFO macro (standard mode, DO_REG=1).
// Issues RDEN against EMPTY, tracks reads in flight through the macro's fixed
// read latency, captures DO into a small local buffer and presents the words
// as a valid/ready stream. Reads are only issued when every outstanding word
// is guaranteed a buffer slot, so backpressure can never drop data.
module xilinx_fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH   = 4,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FIFO_EMPTY,
  input  logic                       FIFO_RDERR,
  input  logic [DATA_WIDTH-1:0]      FIFO_DO,
  output logic                       FIFO_RDEN,
  output logic                       M_VALID,
  input  logic                       M_READY,
  output logic [DATA_WIDTH-1:0]      M_DATA,
  output logic [$clog2(BUF_DEPTH):0] OCCUPANCY,
  output logic                       RDERR_STICKY
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  // One extra bit so occupancy plus in-flight reads can never wrap.
  localparam int PEND_W = OCC_W + 1;
  localparam logic [PEND_W-1:0] DEPTH_LIMIT = PEND_W'(BUF_DEPTH);

  logic [READ_LATENCY-1:0] inflight;
  logic [PEND_W-1:0]       inflight_cnt;
  logic [PEND_W-1:0]       pending;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_WIDTH-1:0]   store [BUF_DEPTH];
  logic                    capture;
  logic                    pop;

  // Count reads already issued to the macro but whose data has not yet landed.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + PEND_W'(inflight[i]);
    end
  end

  // Credit check ignores a same-cycle stream pop; RDEN is also held off in
  // reset so no read is lost while the in-flight tracker is being cleared.
  assign pending   = PEND_W'(OCCUPANCY) + inflight_cnt;
  assign FIFO_RDEN = !RST && !FIFO_EMPTY && (pending < DEPTH_LIMIT);

  assign capture = inflight[READ_LATENCY-1];
  assign M_VALID = (OCCUPANCY != '0);
  assign M_DATA  = store[rd_ptr];
  assign pop     = M_VALID && M_READY;

  generate
    if (READ_LATENCY == 1) begin : g_lat_one
      // Single-cycle latency: the in-flight tracker is just last cycle's RDEN.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          inflight <= '0;
        end else begin
          inflight <= FIFO_RDEN;
        end
      end
    end else begin : g_lat_multi
      // Shift RDEN down the tracker so the top bit marks the cycle DO is valid.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          inflight <= '0;
        end else begin
          inflight <= {inflight[READ_LATENCY-2:0], FIFO_RDEN};
        end
      end
    end
  endgenerate

  // Capture storage has no reset; validity is tracked entirely by OCCUPANCY.
  always_ff @(posedge CLK) begin
    if (capture) begin
      store[wr_ptr] <= FIFO_DO;
    end
  end

  // Ring pointers and occupancy; a simultaneous capture and pop cancel out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      OCCUPANCY <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({capture, pop})
        2'b10:   OCCUPANCY <= OCCUPANCY + 1'b1;
        2'b01:   OCCUPANCY <= OCCUPANCY - 1'b1;
        default: OCCUPANCY <= OCCUPANCY;
      endcase
    end
  end

  // Latch any macro read error until the next reset so misuse is never missed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDERR_STICKY <= 1'b0;
    end else if (FIFO_RDERR) begin
      RDERR_STICKY <= 1'b1;
    end
  end

endmodule
